// File: rtl/mem_burst_responder_if.sv
// Memory-port bundle between the dcache (master) and a burst memory responder (slave).
interface mem_burst_responder_if #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32
);
    logic [ADDRBITS-1:0] mem_addr;
    logic [DATABITS-1:0] mem_in;
    logic [DATABITS-1:0] mem_out;
    logic                mem_out_valid;
    logic                mem_rdreq;
    logic                mem_wrreq;
    logic [15:0]         mem_burstlen;
    logic                mem_busy;

    modport master (
        output mem_addr,
        output mem_in,
        output mem_rdreq,
        output mem_wrreq,
        output mem_burstlen,
        input  mem_out,
        input  mem_out_valid,
        input  mem_busy
    );

    modport slave (
        input  mem_addr,
        input  mem_in,
        input  mem_rdreq,
        input  mem_wrreq,
        input  mem_burstlen,
        output mem_out,
        output mem_out_valid,
        output mem_busy
    );
endinterface

// File: rtl/mem_burst_responder.sv
// Word-addressed RAM answering read/write bursts from the dcache memory port,
// with a configurable read latency and back-to-back read beats.
module mem_burst_responder #(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int MEMADDRBITS = 9,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_burst_responder_if.slave  bus
);
    localparam int DEPTH = 1 << MEMADDRBITS;
    localparam logic [MEMADDRBITS-1:0] PTR_ONE   = MEMADDRBITS'(1);
    localparam logic [3:0]             WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST
    } state_t;

    state_t                  state_reg, state_next;
    logic [MEMADDRBITS-1:0]  ptr_reg, ptr_next;
    logic [15:0]             remaining_reg, remaining_next;
    logic [3:0]              wait_reg, wait_next;
    logic                    busy_reg, busy_next;
    logic                    valid_reg, valid_next;
    logic [DATABITS-1:0]     out_reg;

    logic [DATABITS-1:0]     ram [DEPTH];
    logic                    ram_we;
    logic                    ram_re;
    logic [MEMADDRBITS-1:0]  ram_waddr;
    logic [DATABITS-1:0]     ram_wdata;

    logic [ADDRBITS-1:0]     addr;
    logic [MEMADDRBITS-1:0]  req_idx;
    logic [15:0]             req_len;
    logic                    unused_addr_bits;

    // Byte lanes and bits above the RAM index alias onto the same words.
    assign addr             = bus.mem_addr;
    assign req_idx          = addr[MEMADDRBITS+1:2];
    assign req_len          = (bus.mem_burstlen == 16'd0) ? 16'd1 : bus.mem_burstlen;
    assign unused_addr_bits = ^addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            wait_reg      <= '0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            wait_reg      <= wait_next;
            busy_reg      <= busy_next;
            valid_reg     <= valid_next;
        end
    end

    // busy stays high for one IDLE cycle after a read so it covers the last
    // registered beat; no request is accepted while it is still high.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        wait_next      = wait_reg;
        busy_next      = busy_reg;
        valid_next     = 1'b0;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_waddr      = ptr_reg;
        ram_wdata      = bus.mem_in;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (!busy_reg && bus.mem_wrreq) begin
                    ram_we         = 1'b1;
                    ram_waddr      = req_idx;
                    ptr_next       = req_idx + PTR_ONE;
                    remaining_next = req_len - 16'd1;
                    if (req_len != 16'd1) begin
                        state_next = WR_BURST;
                        busy_next  = 1'b1;
                    end
                end else if (!busy_reg && bus.mem_rdreq) begin
                    ptr_next       = req_idx;
                    remaining_next = req_len;
                    wait_next      = WAIT_INIT;
                    busy_next      = 1'b1;
                    state_next     = (LATENCY == 1) ? RD_BURST : RD_WAIT;
                end
            end

            RD_WAIT: begin
                wait_next = wait_reg - 4'd1;
                if (wait_reg <= 4'd1) begin
                    state_next = RD_BURST;
                end
            end

            RD_BURST: begin
                ram_re         = 1'b1;
                valid_next     = 1'b1;
                ptr_next       = ptr_reg + PTR_ONE;
                remaining_next = remaining_reg - 16'd1;
                if (remaining_reg <= 16'd1) begin
                    state_next = IDLE;
                end
            end

            WR_BURST: begin
                if (bus.mem_wrreq) begin
                    ram_we         = 1'b1;
                    ptr_next       = ptr_reg + PTR_ONE;
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg <= 16'd1) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // RAM contents survive reset; only the write strobe is blocked by it.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg <= '0;
        end else if (ram_re) begin
            out_reg <= ram[ptr_reg];
        end
    end

    assign bus.mem_out       = out_reg;
    assign bus.mem_out_valid = valid_reg;
    assign bus.mem_busy      = busy_reg;
endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench: identical stimulus drives three responders (LATENCY 2, 1, 5);
// expected beats are queued at issue time and checked by a monitor.
module tb_mem_burst_responder;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] addr, din;
    logic        rd, wr;
    logic [15:0] len;

    logic        valid_w [NDUT];
    logic        busy_w  [NDUT];
    logic [31:0] out_w   [NDUT];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    beat_t exp_q [NDUT][$];

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            mem_burst_responder_if #(.DATABITS(32), .ADDRBITS(32)) bus ();
            assign bus.mem_addr     = addr;
            assign bus.mem_in       = din;
            assign bus.mem_rdreq    = rd;
            assign bus.mem_wrreq    = wr;
            assign bus.mem_burstlen = len;
            mem_burst_responder #(
                .DATABITS(32), .ADDRBITS(32), .MEMADDRBITS(9), .LATENCY(lat_of(gi))
            ) dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus)
            );
            assign valid_w[gi] = bus.mem_out_valid;
            assign busy_w[gi]  = bus.mem_busy;
            assign out_w[gi]   = bus.mem_out;
        end
    endgenerate

    function automatic void check(input string name, input int d,
                                  input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s dut%0d (LATENCY=%0d) cycle %0d: got %h, required %h",
                     name, d, lat_of(d), cyc, got, req);
        end
    endfunction

    function automatic void push_beat(input int d, input logic [31:0] data, input int at);
        beat_t b;
        b.data = data;
        b.cyc  = at;
        exp_q[d].push_back(b);
    endfunction

    always @(negedge clk) begin : monitor
        beat_t b;
        for (int d = 0; d < NDUT; d++) begin
            if (valid_w[d] === 1'b1) begin
                check("busy_with_beat", d, {31'b0, busy_w[d]}, 32'd1);
                if (exp_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat dut%0d cycle %0d: got %h, required no beat",
                             d, cyc, out_w[d]);
                end else begin
                    b = exp_q[d].pop_front();
                    check("beat_cycle", d, cyc, b.cyc);
                    check("beat_data", d, out_w[d], b.data);
                    $display("beat dut%0d cycle %0d data %h", d, cyc, out_w[d]);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        rd   = r;
        wr   = w;
        addr = a;
        din  = d;
        len  = l;
    endtask

    task automatic release_bus();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    endtask

    task automatic check_busy_all(input string name, input logic req);
        for (int d = 0; d < NDUT; d++) check(name, d, {31'b0, busy_w[d]}, {31'b0, req});
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < 300);
        if (busy_w[0] || busy_w[1] || busy_w[2]) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout cycle %0d: got busy after %0d cycles, required idle", cyc, n);
        end
    endtask

    // Issue a read and queue n consecutive expected words starting at first.
    task automatic do_read(input logic [31:0] a, input logic [15:0] l,
                           input logic [31:0] first, input int n);
        int e0;
        drive(1'b1, 1'b0, a, 32'h0, l);
        e0 = cyc + 1;
        $display("read addr %h len %0d accepted at cycle %0d", a, l, e0);
        for (int i = 0; i < n; i++)
            for (int d = 0; d < NDUT; d++) push_beat(d, first + i, e0 + lat_of(d) + i);
        release_bus();
        check_busy_all("busy_after_rd_accept", 1'b1);
        wait_idle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e0;
        reset = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; din = '0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_valid", d, {31'b0, valid_w[d]}, 32'd0);
            check("reset_busy", d, {31'b0, busy_w[d]}, 32'd0);
            check("reset_out", d, out_w[d], 32'd0);
        end
        reset = 1'b0;

        // Single write then single read.
        drive(1'b0, 1'b1, 32'h80, 32'h0fff0001, 16'd1);
        release_bus();
        check_busy_all("busy_after_len1_write", 1'b0);
        do_read(32'h80, 16'd1, 32'h0fff0001, 1);

        // 8-beat write with a stall after beat 3; later beats carry a junk address.
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) begin
                drive(1'b0, 1'b0, 32'hffc, 32'hdeadbeef, 16'd8);
                check_busy_all("busy_during_wr_stall", 1'b1);
            end
            drive(1'b0, 1'b1, (i == 1) ? 32'h80 : 32'hffc, 32'h0fff0000 + i, 16'd8);
        end
        release_bus();
        check_busy_all("busy_after_wr_burst", 1'b0);
        do_read(32'h80, 16'd8, 32'h0fff0001, 8);
        do_read(32'h80, 16'd4, 32'h0fff0001, 4);

        // Simultaneous rdreq/wrreq: write wins, no read is started.
        drive(1'b1, 1'b1, 32'h100, 32'ha5a50000, 16'd1);
        release_bus();
        check_busy_all("busy_after_rd_wr_collision", 1'b0);
        do_read(32'h100, 16'd1, 32'ha5a50000, 1);

        // rdreq during WR_BURST, both on a stall cycle and on a write beat.
        drive(1'b0, 1'b1, 32'h200, 32'h22220001, 16'd2);
        drive(1'b1, 1'b0, 32'h200, 32'h0, 16'd2);
        drive(1'b1, 1'b1, 32'h200, 32'h22220002, 16'd2);
        release_bus();
        check_busy_all("busy_after_rd_in_wr_burst", 1'b0);
        do_read(32'h200, 16'd2, 32'h22220001, 2);

        do_read(32'h80, 16'd0, 32'h0fff0001, 1);

        // Wrap-around from word 510 and address aliasing.
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, (i == 0) ? 32'h7f8 : 32'h0, 32'hc0000001 + i, 16'd4);
        release_bus();
        do_read(32'h000, 16'd2, 32'hc0000003, 2);
        do_read(32'h7f8, 16'd2, 32'hc0000001, 2);
        do_read(32'h800, 16'd1, 32'hc0000003, 1);

        // Read accepted on the cycle right after the final write beat.
        drive(1'b0, 1'b1, 32'h300, 32'h33330001, 16'd2);
        drive(1'b0, 1'b1, 32'h0, 32'h33330002, 16'd2);
        do_read(32'h300, 16'd2, 32'h33330001, 2);

        // Reset mid-burst, asserted once the LATENCY=2 responder has shown 3 beats.
        drive(1'b1, 1'b0, 32'h80, 32'h0, 16'd8);
        e0 = cyc + 1;
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 8; i++)
                if (e0 + lat_of(d) + i <= e0 + 4) push_beat(d, 32'h0fff0001 + i, e0 + lat_of(d) + i);
        release_bus();
        while (cyc < e0 + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("midburst_reset_valid", d, {31'b0, valid_w[d]}, 32'd0);
            check("midburst_reset_busy", d, {31'b0, busy_w[d]}, 32'd0);
            check("midburst_reset_out", d, out_w[d], 32'd0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_busy_all("busy_idle_after_reset", 1'b0);
        do_read(32'h80, 16'd8, 32'h0fff0001, 8);

        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL missing_beats dut%0d: got %0d beats outstanding, required 0",
                         d, exp_q[d].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
